alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller that sits on the operand side of the team's registered N-bit ALU and drives it as its initiator. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8-entry register file. It presents opcode, operands and carry-in to the ALU, waits out the ALU's registered latency, then writes the result and carry back. A host write port preloads registers; a debug read port exposes them.

## Interface
- `N`, 32, datapath width; must match the ALU.
- `ALU_LAT`, 1, cycles from operands presented to `alu_result`/`alu_c_out` valid (ALU output register depth), ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `instr`  in  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] c_in, [2:0] reserved (ignored).
- `host_wr_en`  in  1  host register write strobe.
- `host_wr_addr`  in  3  host write index.
- `host_wr_data`  in  N  host write data.
- `alu_mux`  out  3  opcode to ALU: 000 mov, 001 not, 010 add, 011 nor, 100 sub, 101 nand, 110 and, 111 slt.
- `alu_in1`, `alu_in2`  out  N  operands (rs1, rs2 contents).
- `alu_c_in`  out  1  carry-in.
- `alu_result`  in  N  registered ALU result.
- `alu_c_out`  in  1  registered ALU carry/compare flag.
- `done`  out  1  one-cycle pulse per retired instruction.
- `flag`  out  1  last captured carry/compare bit.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  N  combinational read of `regfile[dbg_addr]`.

## Operation
- FSM states: IDLE, WAIT, WB. Encoding: 2-bit binary, IDLE=00.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready` (edge E0), decode:
  - op≠000: register `alu_mux`, `alu_in1`=rf[rs1], `alu_in2`=rf[rs2], `alu_c_in`, latch rd/op; load counter with ALU_LAT; go WAIT.
  - op=000 (mov): handled locally, no ALU transaction; rf[rd]←rf[rs1] at E0, `done` high for the next cycle, stay IDLE; `alu_*` outputs hold previous values.
- WAIT: counter decrements each edge; at zero go WB.
- WB (edge E0+ALU_LAT+1): capture and write rf[rd]:
  - 111 (slt): rf[rd]←{N-1 zeros, `alu_c_out`}.
  - all other ops: rf[rd]←`alu_result`.
  - `flag`←`alu_c_out` only for 010, 100 and 111; holds for all other ops.
  - `done` pulses; return to IDLE.
- `alu_*` outputs are held stable from E0 until the next accepted instruction.
- Register file: writeback and host write in the same cycle:
  - Different addresses: both commit.
  - Same address: writeback wins; host write dropped.
- Host writes are accepted in any state.
- rs1/rs2 equal to rd, or equal to each other: legal; operands are read at E0 (old values).

## Timing
- Reset values: `instr_ready`=1, `alu_mux`=000, `alu_in1`=`alu_in2`=0, `alu_c_in`=0, `done`=0, `flag`=0, all rf entries 0 (so `dbg_data`=0), FSM=IDLE.
- Reset mid-operation aborts: no writeback, no `done`, rf cleared.
- ALU op latency: accept E0 → rf updated and `done` high in the cycle after edge E0+ALU_LAT+1. Next accept no earlier than edge E0+ALU_LAT+2 (default: 3 cycles/instr).
- Mov latency: rf updated at E0, `done` high the following cycle, back-to-back accepts allowed.
- `instr_valid` while busy: instruction must be held by the source; accepted on the first IDLE cycle.
- `dbg_data` reflects writes the cycle after the write edge.

## Structure
- Shared package `alu_pkg`: opcode localparams (OP_MOV … OP_SLT), instruction field positions, FSM state encodings.
- One sub-module `alu_regfile`: 8×N, two combinational read ports plus debug read, writeback port and host port with writeback priority, async reset to 0.

## Test plan
- Host writes r1=5, r2=3; add rd=3 rs1=1 rs2=2 c_in=0; bench ALU model with LAT=1 → `alu_mux`=010, `alu_in1`=5, `alu_in2`=3 after E0; r3=8 and `done` after E2; `flag`=0.
- r1=32'hFFFFFFFF, r2=1, add rd=4 → r4=0, `flag`=1. Then `not` → `flag` still 1.
- r1=3, r2=5, slt rd=5 with model `alu_c_out`=1 → r5=32'h00000001, `flag`=1.
- mov rd=6 rs1=1 twice back-to-back → r6=r1; `done` on two consecutive cycles; `alu_*` unchanged.
- Host write r3=7 in the WB cycle of an op to r3 → r3=ALU result. Same cycle with host write to r2 → r2=7.
- `rst` asserted in WAIT with ALU_LAT=3 → no `done`, all regs 0, `instr_ready`=1 after deassert; held instruction is then accepted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction
// field positions and FSM state encodings.
package alu_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam logic [2:0] OP_MOV  = 3'b000;
  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int CIN_BIT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // Only arithmetic and compare ops produce a meaningful carry/compare bit.
  function automatic logic op_sets_flag(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8 x N register file: two operand read ports, a debug read port, a
// writeback port and a host write port. Writeback wins on address collision.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [N-1:0]      rd_data_a,
  output logic [N-1:0]      rd_data_b,
  output logic [N-1:0]      dbg_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [N-1:0]      wb_data,
  input  logic              host_wr_en,
  input  logic [REG_AW-1:0] host_wr_addr,
  input  logic [N-1:0]      host_wr_data
);

  logic [N-1:0] regs [NUM_REGS];
  logic         host_blocked;

  assign host_blocked = wb_en && (wb_addr == host_wr_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_wr_en && !host_blocked) regs[host_wr_addr] <= host_wr_data;
      if (wb_en) regs[wb_addr] <= wb_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving a registered ALU: decodes instructions, presents
// operands, waits out the ALU latency and writes the result back.
//
// state   | meaning
// IDLE    | ready for an instruction; mov executes here directly
// WAIT    | operands presented, counting down the ALU latency
// WB      | ALU output valid; write rd, update flag, pulse done
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int N       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  input  logic         host_wr_en,
  input  logic [2:0]   host_wr_addr,
  input  logic [N-1:0] host_wr_data,
  output logic [2:0]   alu_mux,
  output logic [N-1:0] alu_in1,
  output logic [N-1:0] alu_in2,
  output logic         alu_c_in,
  input  logic [N-1:0] alu_result,
  input  logic         alu_c_out,
  output logic         done,
  output logic         flag,
  input  logic [2:0]   dbg_addr,
  output logic [N-1:0] dbg_data
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q, rd_q;

  logic [2:0]       f_op, f_rd, f_rs1, f_rs2;
  logic             f_cin;
  logic             unused_rsvd;
  logic             accept, issue_alu;

  logic [N-1:0]     rs1_data, rs2_data;
  logic             wb_en;
  logic [2:0]       wb_addr;
  logic [N-1:0]     wb_data;

  assign f_op        = instr[OP_MSB:OP_LSB];
  assign f_rd        = instr[RD_MSB:RD_LSB];
  assign f_rs1       = instr[RS1_MSB:RS1_LSB];
  assign f_rs2       = instr[RS2_MSB:RS2_LSB];
  assign f_cin       = instr[CIN_BIT];
  assign unused_rsvd = ^instr[2:0];

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign issue_alu   = accept && (f_op != OP_MOV);

  alu_regfile #(.N(N)) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .rd_addr_a    (f_rs1),
    .rd_addr_b    (f_rs2),
    .dbg_addr     (dbg_addr),
    .rd_data_a    (rs1_data),
    .rd_data_b    (rs2_data),
    .dbg_data     (dbg_data),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wb_en     = 1'b0;
    wb_addr   = rd_q;
    wb_data   = alu_result;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (f_op == OP_MOV) begin
            wb_en   = 1'b1;
            wb_addr = f_rd;
            wb_data = rs1_data;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(ALU_LAT - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) state_nxt = ST_WB;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_WB: begin
        wb_en = 1'b1;
        // slt returns only the compare bit, zero-extended
        if (op_q == OP_SLT) wb_data = {{(N-1){1'b0}}, alu_c_out};
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_q     <= OP_MOV;
      rd_q     <= '0;
      alu_mux  <= OP_MOV;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_c_in <= 1'b0;
      done     <= 1'b0;
      flag     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= wb_en;
      if (issue_alu) begin
        alu_mux  <= f_op;
        alu_in1  <= rs1_data;
        alu_in2  <= rs2_data;
        alu_c_in <= f_cin;
        op_q     <= f_op;
        rd_q     <= f_rd;
      end
      if (state == ST_WB && op_sets_flag(op_q)) flag <= alu_c_out;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with behavioural registered ALU models
// (latency 1 on the main instance, latency 3 on the reset-abort instance).
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // main instance, ALU_LAT = 1
  logic        instr_valid, instr_ready, host_wr_en, alu_c_in, alu_c_out, done, flag;
  logic [15:0] instr;
  logic [2:0]  host_wr_addr, alu_mux, dbg_addr;
  logic [31:0] host_wr_data, alu_in1, alu_in2, alu_result, dbg_data;

  // second instance, ALU_LAT = 3
  logic        t_instr_valid, t_instr_ready, t_host_wr_en, t_alu_c_in, t_alu_c_out, t_done, t_flag;
  logic [15:0] t_instr;
  logic [2:0]  t_host_wr_addr, t_alu_mux, t_dbg_addr;
  logic [31:0] t_host_wr_data, t_alu_in1, t_alu_in2, t_alu_result, t_dbg_data;

  alu_issue_ctrl #(.N(32), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .alu_mux(alu_mux), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c_in(alu_c_in),
    .alu_result(alu_result), .alu_c_out(alu_c_out), .done(done), .flag(flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_ctrl #(.N(32), .ALU_LAT(3)) dut_lat3 (
    .clk(clk), .rst(rst), .instr_valid(t_instr_valid), .instr_ready(t_instr_ready), .instr(t_instr),
    .host_wr_en(t_host_wr_en), .host_wr_addr(t_host_wr_addr), .host_wr_data(t_host_wr_data),
    .alu_mux(t_alu_mux), .alu_in1(t_alu_in1), .alu_in2(t_alu_in2), .alu_c_in(t_alu_c_in),
    .alu_result(t_alu_result), .alu_c_out(t_alu_c_out), .done(t_done), .flag(t_flag),
    .dbg_addr(t_dbg_addr), .dbg_data(t_dbg_data)
  );

  // behavioural ALU: {c_out, result}
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    case (op)
      OP_NOT:  return {1'b0, ~a};
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {32'd0, c};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_SUB:  return {1'b0, a} + {1'b0, ~b} + 33'd1;
      OP_NAND: return {1'b0, ~(a & b)};
      OP_AND:  return {1'b0, a & b};
      OP_SLT:  return {(a < b), a - b};
      default: return {1'b0, a};
    endcase
  endfunction

  logic [32:0] p1;
  logic [32:0] p3 [3];
  always @(posedge clk) begin
    p1    <= alu_f(alu_mux, alu_in1, alu_in2, alu_c_in);
    p3[0] <= alu_f(t_alu_mux, t_alu_in1, t_alu_in2, t_alu_c_in);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign {alu_c_out, alu_result}     = p1;
  assign {t_alu_c_out, t_alu_result} = p3[2];

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2, input logic c);
    return {op, rd, rs1, rs2, c, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic t_rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    t_dbg_addr = a;
    #1;
    chk(tag, t_dbg_data, exp);
  endtask

  // waits (bounded) for IDLE, then drives the instruction across one edge (E0)
  task automatic issue(input logic [15:0] w);
    int n = 0;
    while (!instr_ready && n < 20) begin tick(); n++; end
    chk("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] w, input logic [2:0] rd,
                        input logic [31:0] exp);
    issue(w);
    chk({tag, "_busy"}, {31'd0, instr_ready}, 32'd0);
    tick();
    chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    rd_chk({tag, "_rd"}, rd, exp);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 0; instr = '0; host_wr_en = 0; host_wr_addr = '0; host_wr_data = '0; dbg_addr = '0;
    t_instr_valid = 0; t_instr = '0; t_host_wr_en = 0; t_host_wr_addr = '0; t_host_wr_data = '0;
    t_dbg_addr = '0;
    tick(); tick();

    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_mux", {29'd0, alu_mux}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    chk("rst_cin", {31'd0, alu_c_in}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    chk("rst_dbg", dbg_data, 32'd0);
    rst = 1'b0;

    // basic add: 5 + 3
    host_wr(3'd1, 32'd5);
    host_wr(3'd2, 32'd3);
    issue(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0));
    chk("add_mux", {29'd0, alu_mux}, 32'd2);
    chk("add_in1", alu_in1, 32'd5);
    chk("add_in2", alu_in2, 32'd3);
    chk("add_busy", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("add_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("add_done", {31'd0, done}, 32'd1);
    rd_chk("add_r3", 3'd3, 32'd8);
    chk("add_flag", {31'd0, flag}, 32'd0);
    tick();
    chk("add_done_pulse", {31'd0, done}, 32'd0);

    // overflow add sets flag, then not leaves it alone
    host_wr(3'd1, 32'hFFFF_FFFF);
    host_wr(3'd2, 32'd1);
    run_op("add_ovf", mk(OP_ADD, 3'd4, 3'd1, 3'd2, 1'b0), 3'd4, 32'd0);
    chk("add_ovf_flag", {31'd0, flag}, 32'd1);
    run_op("not", mk(OP_NOT, 3'd7, 3'd2, 3'd0, 1'b0), 3'd7, 32'hFFFF_FFFE);
    chk("not_flag_hold", {31'd0, flag}, 32'd1);

    // add with carry-in clears flag, slt sets it and writes only the bit
    host_wr(3'd1, 32'd3);
    host_wr(3'd2, 32'd5);
    run_op("add_cin", mk(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b1), 3'd3, 32'd9);
    chk("add_cin_out", {31'd0, alu_c_in}, 32'd1);
    chk("add_cin_flag", {31'd0, flag}, 32'd0);
    run_op("slt", mk(OP_SLT, 3'd5, 3'd1, 3'd2, 1'b0), 3'd5, 32'd1);
    chk("slt_flag", {31'd0, flag}, 32'd1);

    // back-to-back mov: no ALU transaction, done on two consecutive cycles
    instr = mk(OP_MOV, 3'd6, 3'd1, 3'd0, 1'b0);
    instr_valid = 1'b1;
    tick();
    chk("mov1_done", {31'd0, done}, 32'd1);
    chk("mov1_ready", {31'd0, instr_ready}, 32'd1);
    rd_chk("mov1_r6", 3'd6, 32'd3);
    tick();
    instr_valid = 1'b0;
    chk("mov2_done", {31'd0, done}, 32'd1);
    chk("mov_mux_hold", {29'd0, alu_mux}, 32'd7);
    chk("mov_in1_hold", alu_in1, 32'd3);
    chk("mov_in2_hold", alu_in2, 32'd5);
    tick();
    chk("mov_done_end", {31'd0, done}, 32'd0);

    // host write to rd during WB is dropped
    issue(mk(OP_ADD, 3'd3, 3'd1, 3'd1, 1'b0));
    tick();
    host_wr_en = 1'b1; host_wr_addr = 3'd3; host_wr_data = 32'd7;
    tick();
    host_wr_en = 1'b0;
    chk("coll_done", {31'd0, done}, 32'd1);
    rd_chk("coll_r3", 3'd3, 32'd6);

    // host write to a different register during WB commits alongside
    issue(mk(OP_ADD, 3'd3, 3'd2, 3'd1, 1'b0));
    tick();
    host_wr_en = 1'b1; host_wr_addr = 3'd2; host_wr_data = 32'd7;
    tick();
    host_wr_en = 1'b0;
    rd_chk("both_r3", 3'd3, 32'd8);
    rd_chk("both_r2", 3'd2, 32'd7);

    // rd aliasing both sources reads old value
    run_op("self", mk(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0), 3'd1, 32'd6);

    // instruction held while busy is re-accepted on the first IDLE cycle
    instr = mk(OP_ADD, 3'd4, 3'd1, 3'd2, 1'b0);
    instr_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_idle", {31'd0, instr_ready}, 32'd1);
    rd_chk("hold_r4", 3'd4, 32'd13);
    tick();
    instr_valid = 1'b0;
    chk("hold_reaccept", {31'd0, instr_ready}, 32'd0);
    tick(); tick();

    // reset in WAIT aborts the op on the latency-3 instance
    t_host_wr_en = 1'b1; t_host_wr_addr = 3'd1; t_host_wr_data = 32'd2;
    tick();
    t_host_wr_addr = 3'd2; t_host_wr_data = 32'd4;
    tick();
    t_host_wr_en = 1'b0;
    t_instr = mk(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
    t_instr_valid = 1'b1;
    tick();
    chk("l3_busy", {31'd0, t_instr_ready}, 32'd0);
    chk("l3_mux", {29'd0, t_alu_mux}, 32'd2);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, t_instr_ready}, 32'd1);
    chk("abort_mux", {29'd0, t_alu_mux}, 32'd0);
    t_rd_chk("abort_r1", 3'd1, 32'd0);
    t_rd_chk("abort_r2", 3'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", {31'd0, t_done}, 32'd0);
    end
    t_rd_chk("abort_r3", 3'd3, 32'd0);
    rst = 1'b0;
    tick();
    chk("held_accept_busy", {31'd0, t_instr_ready}, 32'd0);
    chk("held_accept_mux", {29'd0, t_alu_mux}, 32'd2);
    t_instr_valid = 1'b0;
    tick(); tick(); tick();
    chk("l3_done_early", {31'd0, t_done}, 32'd0);
    tick();
    chk("l3_done", {31'd0, t_done}, 32'd1);
    t_rd_chk("l3_r3_zero", 3'd3, 32'd0);

    t_host_wr_en = 1'b1; t_host_wr_addr = 3'd1; t_host_wr_data = 32'd9;
    tick();
    t_host_wr_addr = 3'd2; t_host_wr_data = 32'd1;
    tick();
    t_host_wr_en = 1'b0;
    t_instr_valid = 1'b1;
    tick();
    t_instr_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("l3_done2", {31'd0, t_done}, 32'd1);
    t_rd_chk("l3_r3", 3'd3, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
